// File: rtl/watch_pkg.sv
// Shared constants and types for the 24-hour 7-segment watch.
// Segment vectors are active-low, ordered {g,f,e,d,c,b,a}.
package watch_pkg;

    localparam int unsigned NUM_DIGITS = 7;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned BCD_W      = 4;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    // Time of day as six BCD digits, hours tens in the MSBs.
    typedef struct packed {
        logic [BCD_W-1:0] hr_t;
        logic [BCD_W-1:0] hr_u;
        logic [BCD_W-1:0] mn_t;
        logic [BCD_W-1:0] mn_u;
        logic [BCD_W-1:0] sc_t;
        logic [BCD_W-1:0] sc_u;
    } time_t;

endpackage

// File: rtl/top_artyx_watch_seg7_decoder.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes are blank.
module seg7_decoder
    import watch_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [SEG_W-1:0] seg_c_o
);

    always_comb begin
        seg_c_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_c_o = SEG_0;
            4'd1:    seg_c_o = SEG_1;
            4'd2:    seg_c_o = SEG_2;
            4'd3:    seg_c_o = SEG_3;
            4'd4:    seg_c_o = SEG_4;
            4'd5:    seg_c_o = SEG_5;
            4'd6:    seg_c_o = SEG_6;
            4'd7:    seg_c_o = SEG_7;
            4'd8:    seg_c_o = SEG_8;
            4'd9:    seg_c_o = SEG_9;
            default: seg_c_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/top_artyx_watch.sv
// 24-hour BCD clock multiplexed onto six digits plus a seconds-parity
// indicator slot; display outputs are registered.
module top_artyx_watch
    import watch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic                  CLK100MHZ,
    input  logic                  BTNC,
    output logic [NUM_DIGITS-1:0] AN,
    output logic                  CA,
    output logic                  CB,
    output logic                  CC,
    output logic                  CD,
    output logic                  CE,
    output logic                  CF,
    output logic                  CG
);

    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);

    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    time_t                 time_q, time_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]      seg_q, seg_d;

    logic                  sec_tick_c;
    logic                  scan_wrap_c;
    logic                  c_sc_u, c_sc_t, c_mn_u, c_mn_t, hr_wrap_c;
    logic [BCD_W-1:0]      bcd_sel_c;
    logic [SEG_W-1:0]      dec_seg_c;

    assign sec_tick_c  = (tick_q == TICK_W'(TICK_DIV - 1));
    assign scan_wrap_c = (scan_q == SCAN_W'(SCAN_DIV - 1));

    // Prescalers and digit index
    always_comb begin
        tick_d = sec_tick_c  ? '0 : tick_q + TICK_W'(1);
        scan_d = scan_wrap_c ? '0 : scan_q + SCAN_W'(1);
        idx_d  = idx_q;
        if (scan_wrap_c) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Ripple carry through the BCD time digits, all resolved in one cycle
    always_comb begin
        c_sc_u    = sec_tick_c && (time_q.sc_u == 4'd9);
        c_sc_t    = c_sc_u && (time_q.sc_t == 4'd5);
        c_mn_u    = c_sc_t && (time_q.mn_u == 4'd9);
        c_mn_t    = c_mn_u && (time_q.mn_t == 4'd5);
        hr_wrap_c = c_mn_t && (time_q.hr_t == 4'd2) && (time_q.hr_u == 4'd3);
        time_d    = time_q;
        if (sec_tick_c) time_d.sc_u = c_sc_u ? '0 : time_q.sc_u + 4'd1;
        if (c_sc_u)     time_d.sc_t = c_sc_t ? '0 : time_q.sc_t + 4'd1;
        if (c_sc_t)     time_d.mn_u = c_mn_u ? '0 : time_q.mn_u + 4'd1;
        if (c_mn_u)     time_d.mn_t = c_mn_t ? '0 : time_q.mn_t + 4'd1;
        if (c_mn_t) begin
            if (hr_wrap_c) begin
                time_d.hr_t = '0;
                time_d.hr_u = '0;
            end else if (time_q.hr_u == 4'd9) begin
                time_d.hr_t = time_q.hr_t + 4'd1;
                time_d.hr_u = '0;
            end else begin
                time_d.hr_u = time_q.hr_u + 4'd1;
            end
        end
    end

    always_comb begin
        bcd_sel_c = '0;
        case (idx_q)
            3'd0:    bcd_sel_c = time_q.sc_u;
            3'd1:    bcd_sel_c = time_q.sc_t;
            3'd2:    bcd_sel_c = time_q.mn_u;
            3'd3:    bcd_sel_c = time_q.mn_t;
            3'd4:    bcd_sel_c = time_q.hr_u;
            3'd5:    bcd_sel_c = time_q.hr_t;
            default: bcd_sel_c = '0;
        endcase
    end

    seg7_decoder u_dec (
        .bcd_i   (bcd_sel_c),
        .seg_c_o (dec_seg_c)
    );

    // Slot 6 blinks a dash on even seconds
    always_comb begin
        an_d  = ~(NUM_DIGITS'(1) << idx_q);
        seg_d = dec_seg_c;
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            seg_d = time_q.sc_u[0] ? SEG_BLANK : SEG_DASH;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge BTNC) begin
        if (BTNC) begin
            tick_q <= '0;
            scan_q <= '0;
            idx_q  <= '0;
            time_q <= '0;
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
        end else begin
            tick_q <= tick_d;
            scan_q <= scan_d;
            idx_q  <= idx_d;
            time_q <= time_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign AN = an_q;
    assign {CG, CF, CE, CD, CC, CB, CA} = seg_q;

endmodule

// File: tb/tb_top_artyx_watch.sv
// Directed bench for top_artyx_watch with TICK_DIV=4, SCAN_DIV=2: a hand-computed
// vector table after reset plus a seconds-of-day model checked every cycle.
module tb_top_artyx_watch;
    import watch_pkg::*;

    localparam int unsigned TDIV = 4;
    localparam int unsigned SDIV = 2;

    logic       clk;
    logic       btnc;
    logic [6:0] an;
    logic       ca, cb, cc, cd, ce, cf, cg;
    logic [6:0] seg;

    assign seg = {cg, cf, ce, cd, cc, cb, ca};

    top_artyx_watch #(.TICK_DIV(TDIV), .SCAN_DIV(SDIV)) dut (
        .CLK100MHZ (clk),
        .BTNC      (btnc),
        .AN        (an),
        .CA        (ca),
        .CB        (cb),
        .CC        (cc),
        .CD        (cd),
        .CE        (ce),
        .CF        (cf),
        .CG        (cg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       btnc;
        logic [6:0] an;
        logic [6:0] seg;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    int         m_tick, m_scan, m_idx, m_secs;
    logic [6:0] m_an, m_seg;
    logic       preload;

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] slot_seg(input int idx, input int secs);
        int h, m, s;
        h = secs / 3600;
        m = (secs / 60) % 60;
        s = secs % 60;
        case (idx)
            0: return digit_seg(s % 10);
            1: return digit_seg(s / 10);
            2: return digit_seg(m % 10);
            3: return digit_seg(m / 10);
            4: return digit_seg(h % 10);
            5: return digit_seg(h / 10);
            default: return ((s % 2) == 0) ? 7'b0111111 : 7'b1111111;
        endcase
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tick = 0; m_scan = 0; m_idx = 0; m_secs = 0;
        m_an = 7'h7F; m_seg = 7'h7F;
    endtask

    // One clock edge: advance the model, then compare outputs just after the edge
    task automatic step();
        logic [6:0] an_e;
        @(posedge clk);
        if (btnc) begin
            model_reset();
        end else begin
            an_e = 7'h7F;
            an_e[m_idx] = 1'b0;
            m_an  = an_e;
            m_seg = slot_seg(m_idx, m_secs);
            if (preload)                m_secs = 86399;
            else if (m_tick == TDIV-1)  m_secs = (m_secs + 1) % 86400;
            m_tick = (m_tick == TDIV-1) ? 0 : m_tick + 1;
            if (m_scan == SDIV-1) begin
                m_scan = 0;
                m_idx  = (m_idx == 6) ? 0 : m_idx + 1;
            end else begin
                m_scan = m_scan + 1;
            end
        end
        #1;
        check("an_model", an, m_an);
        check("seg_model", seg, m_seg);
        if (!btnc) check("an_onehot", 7'($countones(~an)), 7'd1);
    endtask

    vec_t tbl[16];
    logic reached;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b0, 7'h7E, 7'h40};
        tbl[1]  = '{1'b0, 7'h7E, 7'h40};
        tbl[2]  = '{1'b0, 7'h7D, 7'h40};
        tbl[3]  = '{1'b0, 7'h7D, 7'h40};
        tbl[4]  = '{1'b0, 7'h7B, 7'h40};
        tbl[5]  = '{1'b0, 7'h7B, 7'h40};
        tbl[6]  = '{1'b0, 7'h77, 7'h40};
        tbl[7]  = '{1'b0, 7'h77, 7'h40};
        tbl[8]  = '{1'b0, 7'h6F, 7'h40};
        tbl[9]  = '{1'b0, 7'h6F, 7'h40};
        tbl[10] = '{1'b0, 7'h5F, 7'h40};
        tbl[11] = '{1'b0, 7'h5F, 7'h40};
        tbl[12] = '{1'b0, 7'h3F, 7'h7F};
        tbl[13] = '{1'b0, 7'h3F, 7'h7F};
        tbl[14] = '{1'b0, 7'h7E, 7'h30};
        tbl[15] = '{1'b0, 7'h7E, 7'h30};

        btnc = 1'b1;
        preload = 1'b0;
        model_reset();
        step();
        step();
        check("rst_an", an, 7'h7F);
        check("rst_seg", seg, 7'h7F);

        // Release and walk the first full scan frame against the vector table
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            btnc = tbl[i].btnc;
            step();
            check($sformatf("tbl_an[%0d]", i), an, tbl[i].an);
            check($sformatf("tbl_seg[%0d]", i), seg, tbl[i].seg);
        end

        // Run to 00:00:09 with the tick counter mid-period, then reset
        reached = 1'b0;
        for (int k = 0; k < 200 && !reached; k++) begin
            step();
            reached = (m_secs == 9 && m_tick == 2);
        end
        check("reach_000009", 7'(reached), 7'd1);
        @(negedge clk);
        btnc = 1'b1;
        model_reset();
        #1;
        check("midrst_an", an, 7'h7F);
        check("midrst_seg", seg, 7'h7F);
        step();
        step();
        @(negedge clk);
        btnc = 1'b0;
        step();
        check("rel_an", an, 7'h7E);
        check("rel_seg", seg, 7'h40);
        for (int k = 0; k < 30; k++) step();

        // Load 23:59:59 in one edge, then roll over to 00:00:00
        @(negedge clk);
        force dut.time_d = time_t'(24'h235959);
        preload = 1'b1;
        step();
        release dut.time_d;
        preload = 1'b0;
        reached = 1'b0;
        for (int k = 0; k < 8 && !reached; k++) begin
            step();
            reached = (m_secs == 0);
        end
        check("rollover_seen", 7'(reached), 7'd1);
        for (int k = 0; k < 14; k++) begin
            step();
            if (an[0] && an[6]) check("rollover_zero", seg, 7'h40);
        end
        for (int k = 0; k < 20; k++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
